// File: rtl/tsetlin_environment.sv
// Stochastic environment that issues reward/penalty feedback to a learning automaton.
// Ports: clk, rst (sync, active-high), start, num_rounds, p0_thresh, p1_thresh, alpha
//        in; beta, beta_valid, busy, done, act1_count, pen_count out.
module tsetlin_environment #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] num_rounds,
   input  logic [7:0]  p0_thresh,
   input  logic [7:0]  p1_thresh,
   input  logic        alpha,
   output logic        beta,
   output logic        beta_valid,
   output logic        busy,
   output logic        done,
   output logic [15:0] act1_count,
   output logic [15:0] pen_count
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        beta_q, beta_d;
   logic        bv_q, bv_d;
   logic [15:0] act1_q, act1_d;
   logic [15:0] pen_q, pen_d;
   logic [15:0] round_q, round_d;
   logic [15:0] nr_q, nr_d;
   logic [7:0]  p0_q, p0_d;
   logic [7:0]  p1_q, p1_d;

   logic [7:0]  thr;
   logic        pen;
   logic        fb;

   // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
   assign fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign thr = alpha ? p1_q : p0_q;
   // Strict compare: thr=0 never penalises, thr=255 misses only lfsr[7:0]=255
   assign pen = (lfsr_q[7:0] < thr);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      beta_d  = 1'b0;
      bv_d    = 1'b0;
      act1_d  = act1_q;
      pen_d   = pen_q;
      round_d = round_q;
      nr_d    = nr_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               nr_d    = num_rounds;
               p0_d    = p0_thresh;
               p1_d    = p1_thresh;
               round_d = 16'd0;
               act1_d  = 16'd0;
               pen_d   = 16'd0;
               state_d = (num_rounds == 16'd0) ? FIN : RUN;
            end
         end
         RUN: begin
            beta_d  = pen;
            bv_d    = 1'b1;
            if (alpha && act1_q != 16'hFFFF) act1_d = act1_q + 16'd1;
            if (pen && pen_q != 16'hFFFF)    pen_d  = pen_q + 16'd1;
            lfsr_d  = {lfsr_q[14:0], fb};
            round_d = round_q + 16'd1;
            if (round_q == nr_q - 16'd1) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_EFF;
         beta_q  <= 1'b0;
         bv_q    <= 1'b0;
         act1_q  <= 16'd0;
         pen_q   <= 16'd0;
         round_q <= 16'd0;
         nr_q    <= 16'd0;
         p0_q    <= 8'd0;
         p1_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         beta_q  <= beta_d;
         bv_q    <= bv_d;
         act1_q  <= act1_d;
         pen_q   <= pen_d;
         round_q <= round_d;
         nr_q    <= nr_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
      end
   end

   assign beta       = beta_q;
   assign beta_valid = bv_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);
   assign act1_count = act1_q;
   assign pen_count  = pen_q;

endmodule

// File: tb/tb_tsetlin_environment.sv
// Scoreboard bench for tsetlin_environment: random and directed runs checked
// against a round-level reference model, plus a closed loop with a 3-bit automaton.
module tb_tsetlin_environment;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_rounds = '0;
   logic [7:0]  p0_thresh = '0;
   logic [7:0]  p1_thresh = '0;
   logic        alpha = 1'b0;
   logic        beta;
   logic        beta_valid;
   logic        busy;
   logic        done;
   logic [15:0] act1_count;
   logic [15:0] pen_count;

   tsetlin_environment dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_rounds (num_rounds),
      .p0_thresh  (p0_thresh),
      .p1_thresh  (p1_thresh),
      .alpha      (alpha),
      .beta       (beta),
      .beta_valid (beta_valid),
      .busy       (busy),
      .done       (done),
      .act1_count (act1_count),
      .pen_count  (pen_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit exp_q[$];
   bit seen[$];
   bit seq_a[$];
   int lfsr_m = 16'hACE1;
   int ta = 3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // x^16+x^14+x^13+x^11+1, shifted left with the parity of the tap bits entering bit 0
   function automatic int lfsr_step(input int l);
      int t;
      t = l & 32'h0000B400;
      return ((l << 1) & 32'hFFFF) | ($countones(t) & 1);
   endfunction

   // Monitor: pops one expectation per presented beta
   initial begin
      bit e;
      forever begin
         @(posedge clk);
         #1;
         if (beta_valid) begin
            seen.push_back(beta);
            if (exp_q.size() == 0) begin
               chk("beta_unexpected", 32'(beta_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beta", 32'(beta), 32'(e));
            end
         end else begin
            chk("beta_idle", 32'(beta), 32'd0);
         end
      end
   end

   // 8-state automaton: states 0..3 choose action 0, 4..7 action 1
   always @(posedge clk) begin
      if (rst) ta <= 3;
      else if (beta_valid) begin
         if (beta) ta <= (ta >= 4) ? ta - 1 : ta + 1;
         else if (ta >= 4) ta <= (ta == 7) ? 7 : ta + 1;
         else ta <= (ta == 0) ? 0 : ta - 1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      alpha = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bv", 32'(beta_valid), 32'd0);
      chk("rst_act1", 32'(act1_count), 32'd0);
      chk("rst_pen", 32'(pen_count), 32'd0);
      lfsr_m = 16'hACE1;
      exp_q.delete();
      rst = 1'b0;
   endtask

   // mode: 0 alpha=1, 1 toggle from 0, 2 random, 3 automaton
   task automatic run(input int nr, input int p0, input int p1,
                      input int mode, input int abort_at);
      int e_act1;
      int e_pen;
      bit a;
      bit pn;
      int thr;
      e_act1 = 0;
      e_pen = 0;
      seen.delete();
      if (!rst) @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      num_rounds = 16'(nr);
      p0_thresh = 8'(p0);
      p1_thresh = 8'(p1);
      for (int r = 0; r < nr; r++) begin
         @(negedge clk);
         if (r == 0) chk("run_busy", 32'(busy), 32'd1);
         if (r == abort_at) begin
            rst = 1'b1;
            start = 1'b0;
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_bv", 32'(beta_valid), 32'd0);
            chk("abort_act1", 32'(act1_count), 32'd0);
            chk("abort_pen", 32'(pen_count), 32'd0);
            chk("abort_lfsr", 32'(dut.lfsr_q), 32'hACE1);
            lfsr_m = 16'hACE1;
            exp_q.delete();
            rst = 1'b0;
            return;
         end
         start = (r == 1) ? 1'b1 : 1'b0;
         num_rounds = 16'($urandom);
         p0_thresh = 8'($urandom);
         p1_thresh = 8'($urandom);
         case (mode)
            0: a = 1'b1;
            1: a = 1'(r % 2);
            2: a = 1'($urandom);
            default: a = (ta >= 4);
         endcase
         alpha = a;
         thr = a ? p1 : p0;
         pn = ((lfsr_m & 255) < thr);
         exp_q.push_back(pn);
         lfsr_m = lfsr_step(lfsr_m);
         e_act1 += int'(a);
         e_pen += int'(pn);
      end
      @(negedge clk);
      chk("fin_done", 32'(done), 32'd1);
      chk("fin_busy", 32'(busy), 32'd1);
      chk("fin_bv", 32'(beta_valid), 32'(nr > 0));
      start = 1'b1;
      num_rounds = 16'd5;
      alpha = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("act1_count", 32'(act1_count), 32'(e_act1));
      chk("pen_count", 32'(pen_count), 32'(e_pen));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      do_reset();
      run(10, 128, 64, 1, -1);
      seq_a = seen;
      run(10, 128, 64, 1, 3);
      run(10, 128, 64, 1, -1);
      chk("repro_len", 32'(seen.size()), 32'(seq_a.size()));
      chk("repro_seq", 32'(seen == seq_a), 32'd1);
      run(4, 0, 0, 0, -1);
      run(0, 200, 200, 2, -1);
      chk("nr0_act1", 32'(act1_count), 32'd0);
      do_reset();
      run(1000, 255, 0, 1, -1);
      for (int i = 0; i < 6; i++)
         run(int'($urandom_range(1, 40)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 2, -1);
      run(3, 255, 255, 2, -1);
      run(2000, 230, 25, 3, -1);
      chk("auto_act1_gt1500", 32'(act1_count > 16'd1500), 32'd1);
      chk("auto_alpha", 32'(ta >= 4), 32'd1);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tsetlin_environment.md
TSETLIN_ENVIRONMENT -- requirements
Module: tsetlin_environment

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, initial LFSR value (16 bits); value 0 SHALL be replaced by 16'hACE1.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a training run.
REQ-005 SHALL have port num_rounds  input  16  number of feedback rounds per run, sampled when start is accepted.
REQ-006 SHALL have port p0_thresh  input  8  penalty probability for action 0, in units of 1/256, sampled when start is accepted.
REQ-007 SHALL have port p1_thresh  input  8  penalty probability for action 1, in units of 1/256, sampled when start is accepted.
REQ-008 SHALL have port alpha  input  1  action currently output by the downstream automaton (0 = action 0, 1 = action 1).
REQ-009 SHALL have port beta  output  1  feedback to the automaton (1 = penalty, 0 = reward), registered.
REQ-010 SHALL have port beta_valid  output  1  high in cycles where beta carries a round's feedback.
REQ-011 SHALL have port busy  output  1  high while a run is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-013 SHALL have port act1_count  output  16  number of rounds in the last or current run where alpha was 1.
REQ-014 SHALL have port pen_count  output  16  number of penalties issued in the last or current run.
REQ-015 SHALL satisfy the fixed decision: one clock; reset is synchronous and active-high.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN, and FIN.
REQ-017 In IDLE, start=1 SHALL latch num_rounds, p0_thresh, and p1_thresh, clear round_cnt, act1_count, and pen_count, and go to RUN; if num_rounds=0, it SHALL go to FIN instead.
REQ-018 start SHALL be ignored in RUN and FIN.
REQ-019 Each RUN cycle SHALL be one round: thr = alpha ? p1_latched : p0_latched; pen = (lfsr[7:0] < thr).
REQ-020 On the edge that ends each RUN cycle, the block SHALL perform all of the following: beta<=pen; beta_valid<=1; act1_count+=alpha; pen_count+=pen; LFSR advance; round_cnt+=1.
REQ-021 beta SHALL therefore lag the sampled alpha by exactly one cycle.
REQ-022 Outside the update cycle in REQ-020, beta_valid SHALL be 0 and beta SHALL be 0.
REQ-023 thr=0 SHALL never give a penalty; thr=255 SHALL give a penalty in 255/256 of LFSR states.
REQ-024 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shift left, feedback into bit 0.
REQ-025 The LFSR SHALL advance only in RUN and SHALL persist across runs (not reseeded by start).
REQ-026 When the round with round_cnt = num_rounds_latched-1 completes, the FSM SHALL go to FIN.
REQ-027 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-029 act1_count and pen_count SHALL saturate at 16'hFFFF and SHALL hold their values in IDLE until the next accepted start.
REQ-030 round_cnt SHALL be 16 bits and SHALL compare against the latched num_rounds, never the live input.
REQ-031 Changes to num_rounds, p0_thresh, or p1_thresh during RUN SHALL have no effect.

Reset
REQ-032 rst=1 at any clock edge, including mid-run, SHALL force: state=IDLE, lfsr=SEED (or 16'hACE1 if SEED=0), beta=0, beta_valid=0, busy=0, done=0, act1_count=0, pen_count=0, round_cnt=0, and all latched config cleared to 0.
REQ-033 rst SHALL have priority over start.
REQ-034 The first start SHALL be accepted on the first edge after rst falls.

Verification
REQ-035 Reset with SEED default, start with num_rounds=4, p0=p1=0, alpha=1 -> beta_valid high for 4 cycles, beta=0 throughout, act1_count=4, pen_count=0, done pulses 1 cycle after last round, busy=0 the cycle after that.
REQ-036 Start with num_rounds=0 -> next cycle FIN (done=1, busy=1, beta_valid never 1), counts=0, IDLE after.
REQ-037 Start with num_rounds=1000, p0=255, p1=0, alpha toggling every cycle -> every beta following alpha=1 is 0; pen_count equals the reference-model count (LFSR model from 16'hACE1, 500 action-0 rounds, about 498); act1_count=500.
REQ-038 Assert rst at round 3 of a 10-round run -> next cycle busy=0, beta_valid=0, counts=0, and the LFSR equals SEED; a new run reproduces the identical beta sequence of a fresh run.
REQ-039 Pulse start again during RUN with different num_rounds and thresholds -> ignored; the run length and penalty pattern match the original configuration.
REQ-040 Loop tsetlin_environment with the 3-bit automaton (beta->automaton, alpha<-automaton), p0=230, p1=25, 2000 rounds -> alpha settles at 1; act1_count > 1500.
